// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential digit-serial multiplier.
package mult_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_e;

  // Width of a counter that must index n digits; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Default configuration: 32x32 operands in 16-bit digits.
  localparam int DEF_A_W   = 32;
  localparam int DEF_B_W   = 32;
  localparam int DEF_CHUNK = 16;
  localparam int DEF_NA    = DEF_A_W / DEF_CHUNK;
  localparam int DEF_NB    = DEF_B_W / DEF_CHUNK;
  localparam int DEF_IW    = cnt_w(DEF_NA);
  localparam int DEF_JW    = cnt_w(DEF_NB);

endpackage

// File: rtl/mult_seq_ctrl.sv
// Controller for the sequential multiplier: FSM plus the i/j digit counters.
// It walks every (i, j) digit pair once, then requests the sign fix-up.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int NA = DEF_NA,
  parameter int NB = DEF_NB,
  parameter int IW = DEF_IW,
  parameter int JW = DEF_JW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          load,
  output logic          acc_en,
  output logic          neg_en,
  output logic [IW-1:0] i_sel,
  output logic [JW-1:0] j_sel
);

  localparam logic [IW-1:0] I_LAST = IW'(NA - 1);
  localparam logic [JW-1:0] J_LAST = JW'(NB - 1);

  mult_state_e   state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;

  // State and counter registers; reset aborts any operation in flight.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // Next-state, counter stepping and datapath strobes.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    acc_en  = 1'b0;
    neg_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy   = 1'b1;
        acc_en = 1'b1;
        if (j_q == J_LAST) begin
          j_d = '0;
          if (i_q == I_LAST) begin
            i_d     = '0;
            state_d = ST_FIX;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_FIX: begin
        busy    = 1'b1;
        neg_en  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        // Back-to-back acceptance skips IDLE entirely.
        if (start) begin
          load    = 1'b1;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign i_sel = i_q;
  assign j_sel = j_q;

endmodule

// File: rtl/mult_seq_param.sv
// Parametrised multi-cycle multiplier. Operands are stored as magnitudes,
// one CHUNKxCHUNK digit product is accumulated per RUN cycle, and the sign
// is applied to the full-width sum in the FIX cycle.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int PW = A_W + B_W;
  localparam int NA = A_W / CHUNK;
  localparam int NB = B_W / CHUNK;
  localparam int IW = cnt_w(NA);
  localparam int JW = cnt_w(NB);

  logic          load, acc_en, neg_en;
  logic [IW-1:0] i_sel;
  logic [JW-1:0] j_sel;

  logic [A_W-1:0] ua_q, ua_d, a_mag;
  logic [B_W-1:0] ub_q, ub_d, b_mag;
  logic           neg_q, neg_d;
  logic [PW-1:0]  product_q, product_d;

  logic [CHUNK-1:0]   a_dig, b_dig;
  logic [2*CHUNK-1:0] pp;
  logic [PW-1:0]      pp_shift;
  logic [31:0]        shamt;

  mult_seq_ctrl #(
    .NA (NA),
    .NB (NB),
    .IW (IW),
    .JW (JW)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .load   (load),
    .acc_en (acc_en),
    .neg_en (neg_en),
    .i_sel  (i_sel),
    .j_sel  (j_sel)
  );

  // Operand magnitudes; unsigned width keeps the most negative value representable.
  always_comb begin
    a_mag = (is_signed && a[A_W-1]) ? -a : a;
    b_mag = (is_signed && b[B_W-1]) ? -b : b;
  end

  // Digit select, partial product and its alignment within the full-width sum.
  always_comb begin
    a_dig    = ua_q[i_sel*CHUNK +: CHUNK];
    b_dig    = ub_q[j_sel*CHUNK +: CHUNK];
    pp       = a_dig * b_dig;
    shamt    = (32'(i_sel) + 32'(j_sel)) * 32'(CHUNK);
    pp_shift = PW'(pp) << shamt;
  end

  // Next values of the operand latches and the accumulator.
  always_comb begin
    ua_d      = ua_q;
    ub_d      = ub_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (load) begin
      ua_d      = a_mag;
      ub_d      = b_mag;
      neg_d     = is_signed & (a[A_W-1] ^ b[B_W-1]);
      product_d = '0;
    end else if (acc_en) begin
      product_d = product_q + pp_shift;
    end else if (neg_en && neg_q) begin
      product_d = -product_q;
    end
  end

  // Datapath registers; cleared by reset so no partial result survives an abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ua_q      <= '0;
      ub_q      <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      ua_q      <= ua_d;
      ub_q      <= ub_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule
